adder_resp_checker: RTL and testbench
=====================================

Name: adder_resp_checker

Overview:
Synthesizable response checker that sits on the output side of the 4-bit lookahead adder. It accepts operand/sum vectors over a valid/ready handshake and recomputes the expected sum with an independent ripple model. It counts passes and failures and latches the first failing vector. It is used both in on-board self-test, with a stimulus source on the input side, and in simulation benches as a scoreboard.

Parameters:
WIDTH, 4, operand and sum width in bits
CNT_W, 8, width of the pass and fail counters

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins a check run and clears results
in_valid  input  1  vector present on c_in/a/b/s
in_ready  output  1  checker can accept a vector this cycle
in_last  input  1  qualifies the final vector of the run
c_in  input  1  carry-in applied to the adder
a  input  WIDTH  operand A applied to the adder
b  input  WIDTH  operand B applied to the adder
s  input  WIDTH  sum returned by the adder
busy  output  1  run in progress (RUN or DRAIN)
done  output  1  run complete; results are stable
pass_cnt  output  CNT_W  number of matching vectors
fail_cnt  output  CNT_W  number of mismatching vectors
fail_seen  output  1  at least one mismatch in the current run
ff_vec  output  3*WIDTH+1  first failing vector, packed as {c_in, a, b, s}

Behaviour:
- Reset is asynchronous and active-high on rst. While rst is high, all outputs are 0 and the state is IDLE. Asserting rst mid-run aborts the run and discards any staged vector.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: in_ready=0. start -> RUN.
  - RUN: in_ready=1, busy=1. An accepted vector with in_last=1 -> DRAIN.
  - DRAIN: in_ready=0, busy=1. After the staged compare completes -> DONE.
  - DONE: done=1. Holds until start -> RUN.
- start (from IDLE or DONE) clears pass_cnt, fail_cnt, fail_seen and ff_vec in the same edge that enters RUN.
- start while in RUN or DRAIN is ignored.
- Acceptance: a vector is accepted at a rising edge where in_valid and in_ready are both 1. The vector is registered into a stage register at that edge (edge E).
- Compare: expected = (a + b + c_in) mod 2^WIDTH, with the carry-out discarded. The result is compared against the staged s, and counters update at edge E+1.
- Throughput: back-to-back acceptance, one vector per cycle, is supported in RUN. The stage register and compare form a 2-deep pipeline with no bubbles.
- Mismatch handling:
  - fail_cnt increments.
  - If fail_seen was 0, ff_vec captures the staged vector and fail_seen is set.
  - Later mismatches never overwrite ff_vec.
- Match: pass_cnt increments.
- Saturation: both counters saturate at 2^CNT_W-1 and never wrap.
- End of run: the last vector is accepted at edge E and counted at E+1. At E+1 the state goes DRAIN -> DONE, so done=1 and the final counts appear in the same cycle.
- in_last with in_valid=0 has no effect.
- A run of one vector (in_last on the first accept) is legal.

Optional Feature:
Macro CHECK_COUT_EN.
- Defined: adds input port cout (1 bit) next to s. The compare uses the full WIDTH+1-bit result {cout, s} against a + b + c_in. ff_vec widens to 3*WIDTH+2, packed as {c_in, a, b, cout, s}.
- Undefined: there is no cout port and the carry-out is ignored, matching the adder, which has no carry-out pin.

Test Plan:
1. Reset during RUN after 3 accepts -> all outputs 0, state IDLE. The next start then 1 vector counts from 0 (pass_cnt=1).
2. start, then the 8 vectors (c_in,a,b,s) as listed, last on the 8th -> pass_cnt=8, fail_cnt=0, done=1 one edge after the 8th accept:
   - (0,0000,0000,0000)
   - (0,1111,1111,1110)
   - (0,1000,1000,0000)
   - (0,1011,0100,1111)
   - (1,1001,1010,0100)
   - (1,1111,0000,0000)
   - (1,0000,0111,1000)
   - (0,0000,0000,0000)
3. Same stream with vectors 3 and 6 corrupted (s=0001 and s=0101) -> fail_cnt=2, pass_cnt=6, fail_seen=1, ff_vec={0,1000,1000,0001}.
4. in_valid held high for 5 consecutive cycles in RUN -> 5 accepts, no stall; a start pulse injected mid-stream is ignored.
5. CNT_W=2, 6 matching vectors -> pass_cnt=3 (saturated), done=1.
6. With CHECK_COUT_EN: (0,1111,1111,cout=1,s=1110) passes; the same vector with cout=0 fails and ff_vec captures cout=0.

Source files
------------

// File: rtl/adder_resp_checker.sv
// ============================================================================
// Module      : adder_resp_checker
// Description : Scoreboard for the 4-bit lookahead adder. Recomputes each sum
//               with a ripple model and counts passes/fails; latches the first
//               failing vector. Optional macro CHECK_COUT_EN adds a cout check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_resp_checker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    input  logic               c_in,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   s,
`ifdef CHECK_COUT_EN
    input  logic               cout,
`endif
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [CNT_W-1:0]   fail_cnt,
    output logic               fail_seen,
`ifdef CHECK_COUT_EN
    output logic [3*WIDTH+1:0] ff_vec
`else
    output logic [3*WIDTH:0]   ff_vec
`endif
);

`ifdef CHECK_COUT_EN
    localparam int RES_W = WIDTH + 1;
`else
    localparam int RES_W = WIDTH;
`endif
    localparam int VEC_W = 2*WIDTH + 1 + RES_W;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_in_ready;
    logic               w_busy;
    logic               w_done;
    logic               w_accept;
    logic               w_clear;
    logic [VEC_W-1:0]   w_in_vec;

    logic               r_stg_valid;
    logic [VEC_W-1:0]   r_stg_vec;
    logic [CNT_W-1:0]   r_pass_cnt;
    logic [CNT_W-1:0]   r_fail_cnt;
    logic               r_fail_seen;
    logic [VEC_W-1:0]   r_ff_vec;

    logic               w_stg_cin;
    logic [WIDTH-1:0]   w_stg_a;
    logic [WIDTH-1:0]   w_stg_b;
    logic [RES_W-1:0]   w_stg_res;
    logic [WIDTH-1:0]   w_carry;
    logic [WIDTH-1:0]   w_exp_sum;
    logic [RES_W-1:0]   w_exp;
    logic               w_mismatch;

`ifdef CHECK_COUT_EN
    assign w_in_vec = {c_in, a, b, cout, s};
`else
    assign w_in_vec = {c_in, a, b, s};
`endif

    assign w_accept = in_valid && w_in_ready;
    assign w_clear  = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_RUN;
            end
            S_RUN: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
                if (w_accept && in_last) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                // Last vector is always staged on entry, so it is counted on the next edge.
                w_busy = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                if (start) w_next = S_RUN;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_stg_cin = r_stg_vec[VEC_W-1];
    assign w_stg_a   = r_stg_vec[VEC_W-2 -: WIDTH];
    assign w_stg_b   = r_stg_vec[VEC_W-2-WIDTH -: WIDTH];
    assign w_stg_res = r_stg_vec[RES_W-1:0];

    // Independent ripple model, deliberately not sharing structure with the lookahead adder.
    assign w_carry[0] = w_stg_cin;
    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        assign w_exp_sum[i] = w_stg_a[i] ^ w_stg_b[i] ^ w_carry[i];
        if (i < WIDTH-1) begin : g_carry
            assign w_carry[i+1] = (w_stg_a[i] & w_stg_b[i]) | (w_carry[i] & (w_stg_a[i] ^ w_stg_b[i]));
        end
    end

`ifdef CHECK_COUT_EN
    assign w_exp = {(w_stg_a[WIDTH-1] & w_stg_b[WIDTH-1]) |
                    (w_carry[WIDTH-1] & (w_stg_a[WIDTH-1] ^ w_stg_b[WIDTH-1])), w_exp_sum};
`else
    assign w_exp = w_exp_sum;
`endif

    assign w_mismatch = (w_stg_res != w_exp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_stg_valid <= 1'b0;
            r_stg_vec   <= '0;
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_fail_seen <= 1'b0;
            r_ff_vec    <= '0;
        end else begin
            r_state     <= w_next;
            r_stg_valid <= w_accept;
            if (w_accept) r_stg_vec <= w_in_vec;

            if (w_clear) begin
                r_pass_cnt  <= '0;
                r_fail_cnt  <= '0;
                r_fail_seen <= 1'b0;
                r_ff_vec    <= '0;
            end else if (r_stg_valid) begin
                if (w_mismatch) begin
                    if (r_fail_cnt != c_CNT_MAX) r_fail_cnt <= r_fail_cnt + 1'b1;
                    if (!r_fail_seen) begin
                        r_ff_vec    <= r_stg_vec;
                        r_fail_seen <= 1'b1;
                    end
                end else if (r_pass_cnt != c_CNT_MAX) begin
                    r_pass_cnt <= r_pass_cnt + 1'b1;
                end
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign busy      = w_busy;
    assign done      = w_done;
    assign pass_cnt  = r_pass_cnt;
    assign fail_cnt  = r_fail_cnt;
    assign fail_seen = r_fail_seen;
    assign ff_vec    = r_ff_vec;

endmodule

`default_nettype wire

// File: tb/tb_adder_resp_checker.sv
// ============================================================================
// Module      : tb_adder_resp_checker
// Description : Directed-vector bench for adder_resp_checker (CNT_W=8 and a
//               saturating CNT_W=2 copy fed the same stream).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_resp_checker;

`ifdef CHECK_COUT_EN
    localparam int FFW = 14;
`else
    localparam int FFW = 13;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, start, in_valid, in_last, c_in;
    logic [3:0]     a, b, s;
`ifdef CHECK_COUT_EN
    logic           cout;
`endif
    logic           in_ready, busy, done, fail_seen;
    logic [7:0]     pass_cnt, fail_cnt;
    logic [FFW-1:0] ff_vec;
    logic           sat_in_ready, sat_busy, sat_done, sat_fail_seen;
    logic [1:0]     sat_pass_cnt, sat_fail_cnt;
    logic [FFW-1:0] sat_ff_vec;

    int n_cmp = 0;
    int n_bad = 0;

    adder_resp_checker #(.WIDTH(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .c_in(c_in), .a(a), .b(b), .s(s),
`ifdef CHECK_COUT_EN
        .cout(cout),
`endif
        .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .fail_seen(fail_seen), .ff_vec(ff_vec)
    );

    adder_resp_checker #(.WIDTH(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(sat_in_ready),
        .in_last(in_last), .c_in(c_in), .a(a), .b(b), .s(s),
`ifdef CHECK_COUT_EN
        .cout(cout),
`endif
        .busy(sat_busy), .done(sat_done), .pass_cnt(sat_pass_cnt), .fail_cnt(sat_fail_cnt),
        .fail_seen(sat_fail_seen), .ff_vec(sat_ff_vec)
    );

    // Packed {c_in, a, b, s}; all eight are correct sums.
    logic [12:0] vecs [8] = '{
        13'b0_0000_0000_0000, 13'b0_1111_1111_1110, 13'b0_1000_1000_0000, 13'b0_1011_0100_1111,
        13'b1_1001_1010_0100, 13'b1_1111_0000_0000, 13'b1_0000_0111_1000, 13'b0_0000_0000_0000
    };

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; vector is accepted at the following posedge.
    task automatic send_raw(input logic ci, input logic [3:0] va, input logic [3:0] vb,
                            input logic co, input logic [3:0] vs, input logic last);
        c_in = ci; a = va; b = vb; s = vs;
`ifdef CHECK_COUT_EN
        cout = co;
`else
        if (co) begin end
`endif
        in_valid = 1'b1;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_vec(input logic [12:0] v, input logic last);
        logic [4:0] full;
        full = {1'b0, v[11:8]} + {1'b0, v[7:4]} + {4'b0, v[12]};
        send_raw(v[12], v[11:8], v[7:4], full[4], v[3:0], last);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [12:0] v;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        c_in = 1'b0; a = '0; b = '0; s = '0;
`ifdef CHECK_COUT_EN
        cout = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_ready", in_ready, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: reset mid-run
        do_start();
        for (int i = 0; i < 3; i++) send_vec(vecs[i], 1'b0);
        check_eq("t1_busy_before_rst", busy, 1);
        rst = 1'b1;
        #1;
        check_eq("t1_busy", busy, 0);
        check_eq("t1_ready", in_ready, 0);
        check_eq("t1_done", done, 0);
        check_eq("t1_pass", pass_cnt, 0);
        check_eq("t1_fail", fail_cnt, 0);
        check_eq("t1_seen", fail_seen, 0);
        check_eq("t1_ffvec", ff_vec, 0);
        @(negedge clk);
        rst = 1'b0;
        do_start();
        send_vec(vecs[0], 1'b1);
        @(negedge clk);
        check_eq("t1_done_after", done, 1);
        check_eq("t1_pass_after", pass_cnt, 1);

        // 2: eight good vectors
        do_start();
        check_eq("t2_pass_clr", pass_cnt, 0);
        for (int i = 0; i < 8; i++) send_vec(vecs[i], i == 7);
        check_eq("t2_done_early", done, 0);
        check_eq("t2_busy_drain", busy, 1);
        @(negedge clk);
        check_eq("t2_done", done, 1);
        check_eq("t2_pass", pass_cnt, 8);
        check_eq("t2_fail", fail_cnt, 0);
        check_eq("t2_seen", fail_seen, 0);
        check_eq("t2_busy", busy, 0);

        // 3: vectors 3 and 6 corrupted
        do_start();
        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            if (i == 2) v[3:0] = 4'b0001;
            if (i == 5) v[3:0] = 4'b0101;
            send_vec(v, i == 7);
        end
        @(negedge clk);
        check_eq("t3_done", done, 1);
        check_eq("t3_pass", pass_cnt, 6);
        check_eq("t3_fail", fail_cnt, 2);
        check_eq("t3_seen", fail_seen, 1);
        check_eq("t3_ffvec", ff_vec, 13'b0_1000_1000_0001);

        // 4: back-to-back, ignored start mid-stream
        do_start();
        check_eq("t4_fail_clr", fail_cnt, 0);
        check_eq("t4_seen_clr", fail_seen, 0);
        check_eq("t4_ffvec_clr", ff_vec, 0);
        for (int i = 0; i < 5; i++) begin
            check_eq("t4_ready", in_ready, 1);
            start = (i == 2);
            send_vec(vecs[i+1], i == 4);
            start = 1'b0;
        end
        @(negedge clk);
        check_eq("t4_done", done, 1);
        check_eq("t4_pass", pass_cnt, 5);
        check_eq("t4_fail", fail_cnt, 0);

        // 5: saturation on the CNT_W=2 copy
        do_start();
        for (int i = 0; i < 6; i++) send_vec(vecs[i], i == 5);
        @(negedge clk);
        check_eq("t5_sat_done", sat_done, 1);
        check_eq("t5_sat_pass", sat_pass_cnt, 3);
        check_eq("t5_sat_fail", sat_fail_cnt, 0);
        check_eq("t5_wide_pass", pass_cnt, 6);

        // in_last without in_valid must not end the run
        do_start();
        in_last = 1'b1;
        @(negedge clk);
        in_last = 1'b0;
        check_eq("t5_last_novalid", busy, 1);
        send_vec(vecs[1], 1'b1);
        @(negedge clk);
        check_eq("t5_one_vec_done", done, 1);
        check_eq("t5_one_vec_pass", pass_cnt, 1);

`ifdef CHECK_COUT_EN
        // 6: carry-out checking
        do_start();
        send_raw(1'b0, 4'hF, 4'hF, 1'b1, 4'hE, 1'b0);
        send_raw(1'b0, 4'hF, 4'hF, 1'b0, 4'hE, 1'b1);
        @(negedge clk);
        check_eq("t6_pass", pass_cnt, 1);
        check_eq("t6_fail", fail_cnt, 1);
        check_eq("t6_ffvec", ff_vec, 14'b0_1111_1111_0_1110);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
